// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and helpers for the framebuffer SRAM arbiter
package sram_pkg;

    localparam int SRAM_AW = 18;
    localparam int D_W     = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    // Pixel address is {x, y}: x lands in the upper bits, y in the lower y_w bits.
    function automatic logic [SRAM_AW-1:0] pix_addr(input logic [SRAM_AW-1:0] x,
                                                   input logic [SRAM_AW-1:0] y,
                                                   input int                 y_w);
        return (x << y_w) | y;
    endfunction

endpackage

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - framebuffer SRAM arbiter: priority pixel reads, req/ack pixel writes
module sram_arbiter #(
    parameter int X_W       = 9,
    parameter int Y_W       = 9,
    parameter int D_W       = sram_pkg::D_W,
    parameter int RD_CYCLES = 2,
    parameter int WR_CYCLES = 2
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic                       rd_req,
    input  logic [X_W-1:0]             rd_x,
    input  logic [Y_W-1:0]             rd_y,
    output logic [D_W-1:0]             rd_data,
    output logic                       rd_valid,
    output logic                       rd_drop,
    input  logic                       wr_req,
    input  logic [X_W-1:0]             wr_x,
    input  logic [Y_W-1:0]             wr_y,
    input  logic [D_W-1:0]             wr_data,
    output logic                       wr_ack,
    output logic                       busy,
    output logic [sram_pkg::SRAM_AW-1:0] SRAM_ADDR,
    inout  wire  [D_W-1:0]             SRAM_DQ,
    output logic                       SRAM_WE_N,
    output logic                       SRAM_OE_N,
    output logic                       SRAM_CE_N,
    output logic                       SRAM_UB_N,
    output logic                       SRAM_LB_N
);
    import sram_pkg::*;

    localparam int MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);

    state_t                 state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic                   pend_valid;
    logic [SRAM_AW-1:0]     pend_addr;
    logic                   dq_oe;
    logic [D_W-1:0]         dq_out;
    logic [SRAM_AW-1:0]     req_addr, wr_addr;
    logic                   rd_launch, wr_grant, rd_done;

    assign req_addr  = pix_addr(SRAM_AW'(rd_x), SRAM_AW'(rd_y), Y_W);
    assign wr_addr   = pix_addr(SRAM_AW'(wr_x), SRAM_AW'(wr_y), Y_W);
    assign rd_launch = (state == IDLE) && (pend_valid || rd_req);
    // wr_ack still high means the requester has not yet seen completion; do not re-grant.
    assign wr_grant  = (state == IDLE) && !(pend_valid || rd_req) && wr_req && !wr_ack;
    assign rd_done   = (state == RD) && (cnt == '0);

    assign busy      = (state != IDLE);
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_DQ   = dq_oe ? dq_out : {D_W{1'bz}};

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (rd_launch) begin
                    state_n = RD;
                    cnt_n   = RD_LOAD;
                end else if (wr_grant) begin
                    state_n = WR_SETUP;
                end
            end
            RD: begin
                if (cnt == '0) state_n = IDLE;
                else           cnt_n   = cnt - CNT_W'(1);
            end
            WR_SETUP: begin
                state_n = WR_PULSE;
                cnt_n   = WR_LOAD;
            end
            WR_PULSE: begin
                if (cnt == '0) state_n = WR_HOLD;
                else           cnt_n   = cnt - CNT_W'(1);
            end
            WR_HOLD: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            SRAM_ADDR  <= '0;
            SRAM_WE_N  <= 1'b1;
            SRAM_OE_N  <= 1'b1;
            dq_oe      <= 1'b0;
            dq_out     <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            rd_drop    <= 1'b0;
            wr_ack     <= 1'b0;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            SRAM_OE_N <= (state_n != RD);
            SRAM_WE_N <= (state_n != WR_PULSE);
            dq_oe     <= (state_n == WR_PULSE) || (state_n == WR_HOLD);
            dq_out    <= wr_data;
            rd_valid  <= rd_done;
            wr_ack    <= (state == WR_HOLD);
            rd_drop   <= rd_req && !rd_launch && pend_valid;
            if (rd_done) rd_data <= SRAM_DQ;
            if (rd_launch)     SRAM_ADDR <= pend_valid ? pend_addr : req_addr;
            else if (wr_grant) SRAM_ADDR <= wr_addr;
            // A request arriving while a pending read launches becomes the next pending read.
            if (rd_req) begin
                pend_addr  <= req_addr;
                pend_valid <= rd_launch ? pend_valid : 1'b1;
            end else if (rd_launch) begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - scoreboard bench for sram_arbiter with a behavioural SRAM
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_req, wr_req;
    logic [8:0]  rd_x, rd_y, wr_x, wr_y;
    logic [15:0] wr_data, rd_data;
    logic        rd_valid, rd_drop, wr_ack, busy;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        we_n, oe_n, ce_n, ub_n, lb_n;

    logic [15:0] mem [0:262143];
    logic        pl_en;
    logic [17:0] pl_addr;
    logic [15:0] pl_data;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_rd_data [$];
    logic [17:0] exp_rd_addr [$];
    logic [33:0] exp_wr [$];
    int          exp_ack = 0;
    int          drop_cnt = 0;
    int          we_pulses = 0;
    logic        p_oe = 1'b1;
    logic        p_we = 1'b1;

    always #10 clk = ~clk;

    sram_arbiter dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .rd_req   (rd_req),
        .rd_x     (rd_x),
        .rd_y     (rd_y),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_drop  (rd_drop),
        .wr_req   (wr_req),
        .wr_x     (wr_x),
        .wr_y     (wr_y),
        .wr_data  (wr_data),
        .wr_ack   (wr_ack),
        .busy     (busy),
        .SRAM_ADDR(sram_addr),
        .SRAM_DQ  (sram_dq),
        .SRAM_WE_N(we_n),
        .SRAM_OE_N(oe_n),
        .SRAM_CE_N(ce_n),
        .SRAM_UB_N(ub_n),
        .SRAM_LB_N(lb_n)
    );

    assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr] : 16'hzzzz;

    always @(posedge clk) begin
        if (pl_en)              mem[pl_addr]   <= pl_data;
        else if (!ce_n && !we_n) mem[sram_addr] <= sram_dq;
    end

    function automatic logic [17:0] pa(input logic [8:0] x, input logic [8:0] y);
        return {x, y};
    endfunction

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [33:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %h expected nothing", name, act);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Scoreboard monitor: pops expectations whenever the DUT presents a result.
    initial begin
        forever begin
            @(negedge clk);
            if (rd_valid) begin
                if (exp_rd_data.size() == 0) flag("rd_valid_unexpected", rd_data);
                else chk("rd_data", rd_data, exp_rd_data.pop_front());
            end
            if (p_oe && !oe_n) begin
                if (exp_rd_addr.size() == 0) flag("rd_addr_unexpected", sram_addr);
                else chk("rd_addr", sram_addr, exp_rd_addr.pop_front());
            end
            if (p_we && !we_n) begin
                we_pulses++;
                if (exp_wr.size() == 0) flag("wr_pulse_unexpected", {sram_addr, sram_dq});
                else chk("wr_addr_data", {sram_addr, sram_dq}, exp_wr.pop_front());
            end
            if (rd_drop) drop_cnt++;
            if (wr_ack) begin
                if (exp_ack == 0) flag("wr_ack_unexpected", wr_ack);
                else exp_ack--;
            end
            p_oe = oe_n;
            p_we = we_n;
        end
    end

    task automatic preload(input logic [17:0] a, input logic [15:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        cyc();
        pl_en   = 1'b0;
    endtask

    task automatic do_read(input logic [8:0] x, input logic [8:0] y,
                           input logic [17:0] ea, input logic [15:0] ed);
        rd_x = x; rd_y = y; rd_req = 1'b1;
        exp_rd_addr.push_back(ea);
        exp_rd_data.push_back(ed);
        cyc();
        rd_req = 1'b0;
        chk("rd_c1_oe", oe_n, 0);
        chk("rd_c1_addr", sram_addr, ea);
        cyc();
        chk("rd_c2_oe", oe_n, 0);
        cyc();
        chk("rd_c3_valid", rd_valid, 1);
        chk("rd_c3_oe", oe_n, 1);
    endtask

    task automatic do_write(input logic [8:0] x, input logic [8:0] y,
                            input logic [15:0] d, input bit hold);
        wr_x = x; wr_y = y; wr_data = d; wr_req = 1'b1;
        exp_wr.push_back({pa(x, y), d});
        exp_ack++;
        cyc();
        chk("wr_setup_we", we_n, 1);
        chk("wr_setup_addr", sram_addr, pa(x, y));
        chk("wr_setup_dq_z", sram_dq !== d, 1);
        cyc();
        chk("wr_pulse1_we", we_n, 0);
        cyc();
        chk("wr_pulse2_we", we_n, 0);
        cyc();
        chk("wr_hold_we", we_n, 1);
        chk("wr_hold_dq", sram_dq, d);
        cyc();
        chk("wr_ack", wr_ack, 1);
        if (hold) begin
            cyc();
            chk("held_no_regrant", busy, 0);
            chk("ack_one_cycle", wr_ack, 0);
        end
        wr_req = 1'b0;
    endtask

    initial begin
        int w0;
        reset = 1'b1; rd_req = 1'b0; wr_req = 1'b0; pl_en = 1'b0;
        rd_x = '0; rd_y = '0; wr_x = '0; wr_y = '0; wr_data = '0;
        pl_addr = '0; pl_data = '0;
        repeat (2) cyc();
        preload(pa(9'd200, 9'd20), 16'h1234);
        preload(pa(9'd300, 9'd400), 16'h5A5A);
        preload(pa(9'd3, 9'd4), 16'hB0B0);
        preload(pa(9'd1, 9'd2), 16'hA0A0);

        chk("rst_we_n", we_n, 1);
        chk("rst_oe_n", oe_n, 1);
        chk("rst_ce_ub_lb", {ce_n, ub_n, lb_n}, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_pulses", {rd_valid, rd_drop, wr_ack}, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        cyc();

        // Idle-bus read with fixed expected address
        do_read(9'd200, 9'd20, 18'h19014, 16'h1234);

        // Single write then readback
        do_write(9'd80, 9'd75, 16'h0001, 1'b0);
        cyc();
        do_read(9'd80, 9'd75, 18'h0A04B, 16'h0001);

        // Held wr_req through ack writes once; reassertion writes again
        cyc();
        w0 = we_pulses;
        do_write(9'd50, 9'd51, 16'h2222, 1'b1);
        cyc();
        cyc();
        chk("held_single_write", we_pulses - w0, 1);
        do_write(9'd50, 9'd51, 16'h3333, 1'b0);
        chk("reassert_new_write", we_pulses - w0, 2);
        cyc();
        do_read(9'd50, 9'd51, pa(9'd50, 9'd51), 16'h3333);

        // Read arriving mid-write is served after ack, ahead of a queued write
        wr_x = 9'd10; wr_y = 9'd11; wr_data = 16'hA5A5; wr_req = 1'b1;
        exp_wr.push_back({pa(9'd10, 9'd11), 16'hA5A5});
        exp_ack++;
        cyc(); cyc();
        rd_x = 9'd300; rd_y = 9'd400; rd_req = 1'b1;
        exp_rd_addr.push_back(pa(9'd300, 9'd400));
        exp_rd_data.push_back(16'h5A5A);
        chk("mid_rd_c2_we", we_n, 0);
        cyc();
        rd_req = 1'b0;
        chk("mid_rd_c3_we", we_n, 0);
        cyc(); cyc();
        chk("mid_rd_ack_c5", wr_ack, 1);
        wr_x = 9'd12; wr_y = 9'd13; wr_data = 16'h0F0F;
        exp_wr.push_back({pa(9'd12, 9'd13), 16'h0F0F});
        exp_ack++;
        cyc();
        chk("mid_rd_c6_oe", oe_n, 0);
        chk("mid_rd_c6_we", we_n, 1);
        cyc(); cyc();
        chk("mid_rd_valid_c8", rd_valid, 1);
        cyc();
        chk("queued_wr_c9_busy", busy, 1);
        chk("queued_wr_c9_addr", sram_addr, pa(9'd12, 9'd13));
        repeat (4) cyc();
        chk("queued_wr_ack_c13", wr_ack, 1);
        wr_req = 1'b0;
        cyc();

        // Two reads during one write: A dropped, only B served
        wr_x = 9'd20; wr_y = 9'd21; wr_data = 16'h1111; wr_req = 1'b1;
        exp_wr.push_back({pa(9'd20, 9'd21), 16'h1111});
        exp_ack++;
        cyc();
        rd_x = 9'd1; rd_y = 9'd2; rd_req = 1'b1;
        cyc();
        rd_req = 1'b0;
        cyc();
        rd_x = 9'd3; rd_y = 9'd4; rd_req = 1'b1;
        exp_rd_addr.push_back(pa(9'd3, 9'd4));
        exp_rd_data.push_back(16'hB0B0);
        cyc();
        rd_req = 1'b0;
        chk("drop_c4", rd_drop, 1);
        cyc();
        chk("drop_c5_clear", rd_drop, 0);
        chk("drop_ack_c5", wr_ack, 1);
        wr_req = 1'b0;
        cyc();
        chk("drop_c6_addr_b", sram_addr, pa(9'd3, 9'd4));
        cyc(); cyc();
        chk("drop_valid_c8", rd_valid, 1);
        chk("drop_count", drop_cnt, 1);
        cyc();

        // Reset during WR_PULSE with a pending read
        wr_x = 9'd30; wr_y = 9'd31; wr_data = 16'hBEEF; wr_req = 1'b1;
        exp_wr.push_back({pa(9'd30, 9'd31), 16'hBEEF});
        cyc();
        rd_x = 9'd5; rd_y = 9'd6; rd_req = 1'b1;
        cyc();
        rd_req = 1'b0;
        chk("rst_mid_pulse_we", we_n, 0);
        reset = 1'b1;
        cyc();
        chk("rst_mid_we_n", we_n, 1);
        chk("rst_mid_dq_z", sram_dq !== 16'hBEEF, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_no_ack", wr_ack, 0);
        reset = 1'b0;
        wr_req = 1'b0;
        repeat (4) cyc();
        chk("rst_after_idle", {busy, rd_valid, wr_ack, oe_n}, 1);

        // Normal operation after reset, plus readbacks of earlier writes
        do_write(9'd40, 9'd41, 16'h7777, 1'b0);
        cyc();
        do_read(9'd40, 9'd41, pa(9'd40, 9'd41), 16'h7777);
        do_read(9'd10, 9'd11, pa(9'd10, 9'd11), 16'hA5A5);
        do_read(9'd12, 9'd13, pa(9'd12, 9'd13), 16'h0F0F);

        repeat (5) cyc();
        chk("left_rd_data", exp_rd_data.size(), 0);
        chk("left_rd_addr", exp_rd_addr.size(), 0);
        chk("left_wr", exp_wr.size(), 0);
        chk("left_ack", exp_ack, 0);
        chk("final_drop_count", drop_cnt, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Owns the single 256Kx16 framebuffer SRAM and shares it between two requesters.
- Requester 1 is a pixel read port fed by the VGA scanout; it has priority.
- Requester 2 is a pixel write port fed by the triangle rasterizer / fill engine; it uses a req/ack handshake.
- Sequences the SRAM control pins with a stretched write pulse and a safe bus turnaround, so neither client drives SRAM pins directly.

Parameters:
- X_W, 9, pixel x coordinate width.
- Y_W, 9, pixel y coordinate width. X_W+Y_W must equal 18.
- D_W, 16, SRAM data width.
- RD_CYCLES, 2, cycles OE_N is held low per read (>=1).
- WR_CYCLES, 2, cycles WE_N is held low per write (>=1).

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rd_req  in  1  single-cycle read request pulse.
- rd_x  in  X_W  read pixel x, sampled with rd_req.
- rd_y  in  Y_W  read pixel y, sampled with rd_req.
- rd_data  out  D_W  read data, held until the next read completes.
- rd_valid  out  1  one-cycle pulse: rd_data updated.
- rd_drop  out  1  one-cycle pulse: a pending read was overwritten.
- wr_req  in  1  level write request; wr_x, wr_y, wr_data held stable until wr_ack.
- wr_x  in  X_W  write pixel x.
- wr_y  in  Y_W  write pixel y.
- wr_data  in  D_W  write data.
- wr_ack  out  1  one-cycle pulse: write completed.
- busy  out  1  high when state is not IDLE.
- SRAM_ADDR  out  18  SRAM address, equal to {x, y}, x in bits [17:9].
- SRAM_DQ  inout  D_W  SRAM data bus.
- SRAM_WE_N  out  1  SRAM write enable, active low.
- SRAM_OE_N  out  1  SRAM output enable, active low.
- SRAM_CE_N  out  1  SRAM chip enable, active low.
- SRAM_UB_N  out  1  SRAM upper byte enable, active low.
- SRAM_LB_N  out  1  SRAM lower byte enable, active low.

Behaviour:
- Reset values:
  - state=IDLE.
  - SRAM_WE_N=1, SRAM_OE_N=1, SRAM_CE_N=0, SRAM_UB_N=0, SRAM_LB_N=0.
  - SRAM_ADDR=0, SRAM_DQ=Z.
  - rd_data=0; rd_valid=0, rd_drop=0, wr_ack=0, busy=0.
  - Pending-read latch cleared.
- All SRAM control and address outputs are registered. SRAM_DQ is driven only in WR_PULSE and WR_HOLD; it is Z in every other state.
- States:
  - IDLE: OE_N=1, WE_N=1.
  - RD: ADDR = read address, OE_N=0, held for RD_CYCLES cycles. DQ is sampled into rd_data on the last RD edge; rd_valid pulses the following cycle.
  - WR_SETUP: 1 cycle. ADDR = write address, OE_N=1, WE_N=1, DQ=Z. This is the bus turnaround.
  - WR_PULSE: WR_CYCLES cycles. WE_N=0, DQ driven with wr_data.
  - WR_HOLD: 1 cycle. WE_N=1, DQ still driven. Then go to IDLE with wr_ack=1 in that IDLE cycle.
- Arbitration in IDLE (checked in this order):
  - A pending read, or rd_req in the current cycle, goes to RD.
  - Otherwise wr_req=1 and wr_ack=0 goes to WR_SETUP.
  - wr_ack=1 blocks re-grant for that cycle, so a held wr_req is not written twice.
- Latency with defaults:
  - rd_req in IDLE at cycle 0 gives RD in cycles 1-2 and rd_valid at cycle 3.
  - wr_req at cycle 0 gives SETUP at 1, PULSE at 2-3, HOLD at 4, wr_ack at 5.
- rd_req while busy: address captured into a one-deep pending latch and served immediately after the current operation, ahead of any write.
- rd_req while a read is already pending: the latch takes the newer address and rd_drop pulses.
- rd_req in the same cycle a pending read is launched: that rd_req becomes the new pending read.
- Writes are never interrupted. A read arriving mid-write waits at most WR_CYCLES+2 cycles.
- wr_req deasserted before wr_ack: ignored if still in IDLE; an operation already started completes and still acks.
- Reset mid-operation: next edge goes to IDLE with WE_N=1 and DQ=Z. No wr_ack or rd_valid is issued, and the pending read is cleared.

Decomposition:
- Package sram_pkg holds:
  - state enum (IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD);
  - SRAM_AW=18 and D_W constants;
  - pixel-to-address pack function {x, y}.
- One phase-length down-counter, sized for max(RD_CYCLES, WR_CYCLES), is shared by all states.
- No sub-module; the tristate and pending latch are inline.

Test Plan:
- Read, idle bus, model holds 16'h1234 at {9'd200, 9'd20}: rd_req pulse at cycle 0 -> OE_N low in cycles 1-2, ADDR=18'h19014, rd_valid at cycle 3, rd_data=16'h1234.
- Write {9'd80, 9'd75} = 16'h0001 -> WE_N low exactly 2 cycles, DQ Z during SETUP, wr_ack at cycle 5. A readback then returns 16'h0001.
- Held wr_req through wr_ack -> exactly one write cycle is observed. The next request is a new write only if wr_req is reasserted after the ack.
- rd_req at cycle 2 during a write started at cycle 0 -> the write completes unaltered. RD starts in the cycle after wr_ack and preempts a queued second write. rd_valid follows at wr_ack+3.
- Two rd_req pulses (A, then B) during one write -> rd_drop pulses once. Only B is read and returned; A is never seen on ADDR.
- reset asserted during WR_PULSE -> WE_N=1 and DQ=Z on the next edge, no wr_ack. Contents at that address are not checked, and subsequent operations behave normally.
